// File: rtl/execute_cc_stage_if.sv
// Execute-stage bus: decoded instruction in, retired result and status out.
interface execute_cc_stage_if #(
    parameter int unsigned DATA_W = 64
);
    logic              valid_i;
    logic              stall_i;
    logic [3:0]        icode_i;
    logic [3:0]        ifun_i;
    logic [DATA_W-1:0] valA_i;
    logic [DATA_W-1:0] valB_i;
    logic [DATA_W-1:0] valC_i;

    logic              valid_o;
    logic [3:0]        icode_o;
    logic [DATA_W-1:0] valE_o;
    logic              Cnd_o;
    logic [2:0]        cc_o;
    logic              halted_o;
    logic              err_o;

    // Decode side: drives the instruction, observes the result.
    modport master (
        output valid_i, stall_i, icode_i, ifun_i, valA_i, valB_i, valC_i,
        input  valid_o, icode_o, valE_o, Cnd_o, cc_o, halted_o, err_o
    );

    // Execute stage: consumes the instruction, drives the result.
    modport slave (
        input  valid_i, stall_i, icode_i, ifun_i, valA_i, valB_i, valC_i,
        output valid_o, icode_o, valE_o, Cnd_o, cc_o, halted_o, err_o
    );
endinterface

// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: ALU, condition-code register, branch/cmov
// condition evaluation and sticky halt/error status.
module execute_cc_stage #(
    parameter int unsigned DATA_W = 64,
    parameter logic [2:0]  CC_RST = 3'b100
) (
    input logic             clk_i,
    input logic             rst_n_i,
    execute_cc_stage_if.slave bus
);
    localparam int unsigned MSB = DATA_W - 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [3:0]        icode_q, icode_d;
    logic [DATA_W-1:0] valE_q, valE_d;
    logic              cnd_q, cnd_d;
    logic [2:0]        cc_q, cc_d;

    logic              illegal;
    logic              accept;
    logic [DATA_W-1:0] aluA, aluB, alu_res;
    logic              alu_of;
    logic              cond;
    logic              zf, sf, of;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    // Illegal instruction detection.
    always_comb begin
        illegal = 1'b0;
        if (bus.icode_i > 4'hB) begin
            illegal = 1'b1;
        end else if (bus.icode_i == 4'h6 && bus.ifun_i > 4'h3) begin
            illegal = 1'b1;
        end else if ((bus.icode_i == 4'h2 || bus.icode_i == 4'h7) && bus.ifun_i > 4'h6) begin
            illegal = 1'b1;
        end
    end

    // ALU operand selection by instruction class.
    always_comb begin
        aluA = '0;
        aluB = '0;
        unique case (bus.icode_i)
            4'h2, 4'h6:       aluA = bus.valA_i;
            4'h3, 4'h4, 4'h5: aluA = bus.valC_i;
            4'h8, 4'hA:       aluA = {{(DATA_W-4){1'b1}}, 4'b1000};
            4'h9, 4'hB:       aluA = DATA_W'(8);
            default:          aluA = '0;
        endcase
        unique case (bus.icode_i)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: aluB = bus.valB_i;
            default:                                  aluB = '0;
        endcase
    end

    // ALU function and signed-overflow flag; only OPq selects a non-add op.
    always_comb begin
        alu_res = aluB + aluA;
        alu_of  = (aluA[MSB] == aluB[MSB]) && (alu_res[MSB] != aluA[MSB]);
        if (bus.icode_i == 4'h6) begin
            unique case (bus.ifun_i)
                4'h1: begin
                    alu_res = aluB - aluA;
                    alu_of  = (aluA[MSB] != aluB[MSB]) && (alu_res[MSB] != aluB[MSB]);
                end
                4'h2: begin
                    alu_res = aluB & aluA;
                    alu_of  = 1'b0;
                end
                4'h3: begin
                    alu_res = aluB ^ aluA;
                    alu_of  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Branch/cmov condition from the CC value held before this cycle's update.
    always_comb begin
        cond = 1'b0;
        unique case (bus.ifun_i)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~(sf ^ of);
            4'h6:    cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
    end

    // Next-state: accept/retire, stall hold, sticky halt/error transitions.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        icode_d = icode_q;
        valE_d  = valE_q;
        cnd_d   = cnd_q;
        cc_d    = cc_q;
        accept  = bus.valid_i & ~bus.stall_i & (state_q == ST_RUN);
        if (accept) begin
            valid_d = 1'b1;
            icode_d = bus.icode_i;
            if (illegal) begin
                valE_d  = '0;
                cnd_d   = 1'b0;
                state_d = ST_ERROR;
            end else if (bus.icode_i == 4'h0) begin
                valE_d  = '0;
                cnd_d   = 1'b0;
                state_d = ST_HALTED;
            end else begin
                valE_d = alu_res;
                cnd_d  = (bus.icode_i == 4'h2 || bus.icode_i == 4'h7) ? cond : 1'b0;
                if (bus.icode_i == 4'h6) begin
                    cc_d = {alu_res == '0, alu_res[MSB], alu_of};
                end
            end
        end else if (!bus.stall_i) begin
            valid_d = 1'b0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            icode_q <= 4'h1;
            valE_q  <= '0;
            cnd_q   <= 1'b0;
            cc_q    <= CC_RST;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            icode_q <= icode_d;
            valE_q  <= valE_d;
            cnd_q   <= cnd_d;
            cc_q    <= cc_d;
        end
    end

    assign bus.valid_o  = valid_q;
    assign bus.icode_o  = icode_q;
    assign bus.valE_o   = valE_q;
    assign bus.Cnd_o    = cnd_q;
    assign bus.cc_o     = cc_q;
    assign bus.halted_o = (state_q == ST_HALTED);
    assign bus.err_o    = (state_q == ST_ERROR);
endmodule

// File: tb/tb_execute_cc_stage.sv
// Scoreboard bench for execute_cc_stage: a behavioural Y86 model pushes the
// expected registered outputs as each instruction is driven; they are popped
// and compared one cycle later.
module tb_execute_cc_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    execute_cc_stage_if #(.DATA_W(64)) bus ();

    execute_cc_stage #(.DATA_W(64), .CC_RST(3'b100)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic        cnd;
        logic [2:0]  cc;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state.
    logic        m_valid, m_cnd, m_halt, m_err;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [2:0]  m_cc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_icode = 4'h1; m_valE = '0; m_cnd = 1'b0;
        m_cc = 3'b100; m_halt = 1'b0; m_err = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.valid = m_valid; e.icode = m_icode; e.valE = m_valE; e.cnd = m_cnd;
        e.cc = m_cc; e.halted = m_halt; e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".valid"},  64'(bus.valid_o),  64'(e.valid));
        check({tag, ".icode"},  64'(bus.icode_o),  64'(e.icode));
        check({tag, ".valE"},   bus.valE_o,        e.valE);
        check({tag, ".Cnd"},    64'(bus.Cnd_o),    64'(e.cnd));
        check({tag, ".cc"},     64'(bus.cc_o),     64'(e.cc));
        check({tag, ".halted"}, 64'(bus.halted_o), 64'(e.halted));
        check({tag, ".err"},    64'(bus.err_o),    64'(e.err));
    endtask

    // Reference semantics of one clock edge with the given inputs.
    task automatic model_step(input logic v, input logic s, input logic [3:0] ic,
                              input logic [3:0] fn, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] c);
        logic bad, zf, sf, of, sxo;
        logic [63:0] r;
        zf = m_cc[2]; sf = m_cc[1]; of = m_cc[0]; sxo = sf ^ of;
        if (s) return;
        if (!v || m_halt || m_err) begin
            m_valid = 1'b0;
            return;
        end
        m_valid = 1'b1;
        m_icode = ic;
        bad = (ic > 4'hB) || (ic == 4'h6 && fn > 4'h3) ||
              ((ic == 4'h2 || ic == 4'h7) && fn > 4'h6);
        m_cnd = 1'b0;
        if (bad) begin
            m_valE = '0; m_err = 1'b1;
        end else if (ic == 4'h0) begin
            m_valE = '0; m_halt = 1'b1;
        end else begin
            case (ic)
                4'h2:       m_valE = a;
                4'h3:       m_valE = c;
                4'h4, 4'h5: m_valE = b + c;
                4'h8, 4'hA: m_valE = b - 64'd8;
                4'h9, 4'hB: m_valE = b + 64'd8;
                4'h6: begin
                    case (fn)
                        4'h0: begin r = b + a; of = (a[63] == b[63]) && (r[63] != a[63]); end
                        4'h1: begin r = b - a; of = (a[63] != b[63]) && (r[63] != b[63]); end
                        4'h2: begin r = b & a; of = 1'b0; end
                        default: begin r = b ^ a; of = 1'b0; end
                    endcase
                    m_valE = r;
                    m_cc = {(r == 64'd0), r[63], of};
                end
                default:    m_valE = '0;
            endcase
            if (ic == 4'h2 || ic == 4'h7) begin
                case (fn)
                    4'h0: m_cnd = 1'b1;
                    4'h1: m_cnd = sxo | zf;
                    4'h2: m_cnd = sxo;
                    4'h3: m_cnd = zf;
                    4'h4: m_cnd = ~zf;
                    4'h5: m_cnd = ~sxo;
                    default: m_cnd = ~sxo & ~zf;
                endcase
            end
        end
    endtask

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic step(input string tag, input logic v, input logic s,
                        input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bus.valid_i = v; bus.stall_i = s; bus.icode_i = ic; bus.ifun_i = fn;
        bus.valA_i = a; bus.valB_i = b; bus.valC_i = c;
        model_step(v, s, ic, fn, a, b, c);
        push_exp();
        @(posedge clk);
        #1;
        pop_compare(tag);
    endtask

    // Assert reset mid-cycle and check the clear happens without a clock edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        pop_compare(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c;
        logic        v, s;

        bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.icode_i = 4'h1; bus.ifun_i = 4'h0;
        bus.valA_i = '0; bus.valB_i = '0; bus.valC_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_exp();
        pop_compare("reset");
        rst_n = 1'b1;

        step("irmovq", 1, 0, 4'h3, 4'h0, 64'd0, 64'd0, 64'd1);
        step("addq",   1, 0, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
        step("subq0",  1, 0, 4'h6, 4'h1, 64'd2, 64'd2, 64'd0);
        step("cmovle", 1, 0, 4'h2, 4'h1, 64'd4, 64'd0, 64'd0);
        step("jne",    1, 0, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        step("addq_of", 1, 0, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        step("subq_of", 1, 0, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        step("pushq",  1, 0, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        step("popq",   1, 0, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
        step("andq",   1, 0, 4'h6, 4'h2, 64'hF0F0, 64'h0F0F, 64'd0);
        step("xorq",   1, 0, 4'h6, 4'h3, 64'h8000_0000_0000_0001, 64'd1, 64'd0);
        step("mrmovq", 1, 0, 4'h5, 4'h0, 64'd0, 64'h40, 64'h10);
        step("stall",  1, 1, 4'h6, 4'h0, 64'd5, 64'd5, 64'd0);
        step("idle",   0, 0, 4'h6, 4'h0, 64'd5, 64'd5, 64'd0);

        for (int i = 0; i < 60; i++) begin
            ic = 4'($urandom_range(1, 11));
            if (ic == 4'h6)                   fn = 4'($urandom_range(0, 3));
            else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
            else                              fn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
            end else begin
                a = 64'($urandom_range(0, 3)); b = 64'($urandom_range(0, 3));
            end
            c = {$urandom, $urandom};
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            step("rand", v, s, ic, fn, a, b, c);
        end

        step("halt",       1, 0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        step("post_halt",  1, 0, 4'h6, 4'h0, 64'd3, 64'd4, 64'd0);
        async_reset("rst_halt");
        step("illegal_C",  1, 0, 4'hC, 4'h0, 64'd0, 64'd0, 64'd0);
        step("post_err",   1, 0, 4'h3, 4'h0, 64'd0, 64'd0, 64'd9);
        async_reset("rst_err");
        step("opq_ifun4",  1, 0, 4'h6, 4'h4, 64'd1, 64'd1, 64'd0);
        async_reset("rst_err2");
        step("jxx_ifun6",  1, 0, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
        step("cmov_ifun7", 1, 0, 4'h2, 4'h7, 64'd1, 64'd0, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/execute_cc_stage.md
Name: execute_cc_stage

Overview:
- Y86-64 execute stage with condition-code (CC) register.
- Sits between the decode/writeback register file and the memory/writeback side.
- Consumes decoded icode/ifun and valA/valB/valC; produces registered valE and Cnd, which the register file consumes on writeback.
- Owns the ZF/SF/OF state and the sticky halt/error status.

Parameters:
- DATA_W, 64, datapath width in bits. Only 64 is verified.
- CC_RST, 3'b100, CC value loaded at reset, ordered {ZF,SF,OF}.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  instruction present on inputs.
- stall_i  in  1  hold all state this cycle.
- icode_i  in  4  instruction code.
- ifun_i  in  4  function code.
- valA_i  in  DATA_W  register operand A.
- valB_i  in  DATA_W  register operand B.
- valC_i  in  DATA_W  constant word.
- valid_o  out  1  registered outputs hold a retired instruction.
- icode_o  out  4  registered icode.
- valE_o  out  DATA_W  registered ALU result.
- Cnd_o  out  1  registered condition result.
- cc_o  out  3  current CC {ZF,SF,OF}.
- halted_o  out  1  sticky; halt instruction accepted.
- err_o  out  1  sticky; illegal icode or ifun accepted.

Behaviour:
- Reset (async, rst_n_i=0): valid_o=0, icode_o=4'h1, valE_o=0, Cnd_o=0, cc_o=CC_RST, halted_o=0, err_o=0.
  - Reset asserted mid-operation clears state immediately, with no clock edge needed.
  - The first accept is possible on the first rising edge after deassertion.
- Accept condition: valid_i & ~stall_i & ~halted_o & ~err_o at a rising edge.
  - Latency is 1 cycle: outputs reflect the accepted instruction after that edge.
- No accept, with stall_i=1: all outputs and CC hold.
- No accept otherwise: valid_o<=0; other outputs hold.
- aluA selection:
  - icode 2 and 6: valA.
  - icode 3, 4, 5: valC.
  - icode 8 and A: -8.
  - icode 9 and B: +8.
  - All other icodes: 0.
- aluB selection:
  - icode 4, 5, 6, 8, 9, A, B: valB.
  - All other icodes: 0.
- ALU function:
  - icode 6 uses ifun: 0 add (aluB+aluA), 1 sub (aluB-aluA), 2 and, 3 xor.
  - All other icodes: add.
  - Arithmetic is modulo 2^DATA_W, with no carry out.
- CC update happens only on an accepted icode 6 with ifun<=3:
  - ZF = (result==0).
  - SF = result[MSB].
  - OF for add: operands share a sign and the result sign differs from it.
  - OF for sub: the signs of valB and valA differ and the result sign differs from valB's.
  - OF = 0 for and/xor.
  - The new CC is visible on cc_o in the same cycle that valE_o is visible.
- Cnd (for icode 2 and 7) is evaluated from CC before any update in that cycle:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF)&~ZF.
  - For all other icodes, Cnd_o=0.
- Errors: icode>4'hB, icode 6 with ifun>3, or icode 2/7 with ifun>6.
  - Outputs: valid_o=1, valE_o=0, Cnd_o=0, err_o<=1.
  - CC is unchanged.
  - Acceptance stops thereafter.
- Halt: icode 0 accepted.
  - Outputs: valid_o=1, valE_o=0, halted_o<=1.
  - CC is unchanged.
  - Later inputs are ignored (valid_o=0 next cycle) until reset.
- Reset is the only way to clear halted_o or err_o.

Test Plan:
- Reset: after rst_n_i low then high, expect cc_o=3'b100, valid_o=0, valE_o=0, halted_o=0, err_o=0.
- irmovq: icode=3, valC=1 -> next cycle valE_o=1, cc_o=3'b100 unchanged.
  - Then addq: icode=6, ifun=0, valA=1, valB=2 -> valE_o=3, cc_o=3'b000.
- subq: valA=2, valB=2 -> valE_o=0, cc_o=3'b100.
  - Then cmovle: icode=2, ifun=1, valA=4 -> Cnd_o=1, valE_o=4.
  - Then jne: icode=7, ifun=4 -> Cnd_o=0.
- Overflow: addq with valA=64'h7FFF_FFFF_FFFF_FFFF, valB=1 -> valE_o=64'h8000_0000_0000_0000, cc_o=3'b011.
  - Then subq with valA=1, valB=64'h8000_0000_0000_0000 -> valE_o=64'h7FFF_FFFF_FFFF_FFFF, cc_o=3'b001.
- Stack ops: pushq with valB=64'h100 -> valE_o=64'hF8. popq with valB=64'h100 -> valE_o=64'h108. Neither changes CC.
- Stall, halt and reset:
  - Stall: stall_i=1 during an addq -> outputs and cc_o frozen.
  - Halt: halt accepted -> halted_o=1; a following addq is ignored and cc_o is unchanged.
  - Illegal: icode=4'hC -> err_o=1.
  - Reset: asserting rst_n_i=0 mid-cycle clears halted_o and err_o without any clock edge.
